// File: rtl/median_frame_ctrl_pkg.sv
// Shared types and widths for the median filter frame controller.
package median_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int WIN    = 5;
  localparam int RUN_W  = 11;
  localparam int LINE_W = 10;

endpackage

// File: rtl/median_frame_ctrl_de_run_counter.sv
// Edge detection on de/vsync and saturating measurement of de run lengths.
module median_frame_ctrl_de_run_counter
  import median_frame_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic             i_de,
  input  logic             i_vsync,
  output logic             o_vs_rise,
  output logic             o_run_done,
  output logic [RUN_W-1:0] o_run
);

  logic             r_de_d;
  logic             r_vs_d;
  logic             r_valid;
  logic [RUN_W-1:0] r_cnt;
  logic             w_de_rise;
  logic             w_de_fall;
  logic             w_vs_rise;

  assign w_de_rise = i_ce & i_de & ~r_de_d;
  assign w_de_fall = i_ce & ~i_de & r_de_d;
  assign w_vs_rise = i_ce & i_vsync & ~r_vs_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_de_d  <= 1'b0;
      r_vs_d  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (i_ce) begin
      r_de_d <= i_de;
      r_vs_d <= i_vsync;
      if (i_de) begin
        if (w_de_rise)
          r_cnt <= RUN_W'(1);
        else if (r_cnt != '1)
          r_cnt <= r_cnt + RUN_W'(1);
      end
      // A vsync edge invalidates any run still in progress.
      if (w_vs_rise)
        r_valid <= 1'b0;
      else if (w_de_rise)
        r_valid <= 1'b1;
    end
  end

  assign o_vs_rise  = w_vs_rise;
  assign o_run_done = w_de_fall & r_valid & ~w_vs_rise;
  assign o_run      = r_cnt;

endmodule

// File: rtl/median_frame_ctrl.sv
// Measures active line width, locks after a verified frame and drives h_size/filt_en.
module median_frame_ctrl
  import median_frame_ctrl_pkg::*;
#(
  parameter int DEFAULT_H = 83,
  parameter int MIN_W     = 8,
  parameter int MAX_W     = 1023,
  parameter int MIN_LINES = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_de,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_force_bypass,
  output logic [LINE_W-1:0] o_h_size,
  output logic              o_filt_en,
  output logic              o_locked,
  output logic              o_err,
  output logic [RUN_W-1:0]  o_width,
  output logic [LINE_W-1:0] o_lines
);

  state_t            r_state, w_state_next;
  logic [RUN_W-1:0]  r_w, w_w_next;
  logic [LINE_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [LINE_W-1:0] r_h_size, w_h_size_next;
  logic [LINE_W-1:0] r_lines, w_lines_next;
  logic [RUN_W-1:0]  r_width, w_width_next;
  logic              r_locked, w_locked_next;
  logic              r_filt_en, w_filt_en_next;
  logic              r_err, w_err_next;
  logic              w_vs_rise, w_run_done, w_match, w_in_range;
  logic [RUN_W-1:0]  w_run;
  logic              w_unused;

  assign w_unused = i_hsync;

  median_frame_ctrl_de_run_counter u_run (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ce       (i_ce),
    .i_de       (i_de),
    .i_vsync    (i_vsync),
    .o_vs_rise  (w_vs_rise),
    .o_run_done (w_run_done),
    .o_run      (w_run)
  );

  assign w_match    = (w_run == r_w);
  assign w_in_range = (w_run >= RUN_W'(MIN_W)) && (w_run <= RUN_W'(MAX_W));
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + LINE_W'(1);

  always_comb begin
    w_state_next  = r_state;
    w_w_next      = r_w;
    w_cnt_next    = r_cnt;
    w_h_size_next = r_h_size;
    w_lines_next  = r_lines;
    w_locked_next = r_locked;
    w_err_next    = 1'b0;
    w_width_next  = w_run_done ? w_run : r_width;
    unique case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_state_next = ST_MEASURE;
          w_cnt_next   = '0;
        end
      end
      ST_MEASURE: begin
        if (w_vs_rise) begin
          w_cnt_next = '0;
        end else if (w_run_done) begin
          w_w_next = w_run;
          if (w_in_range) begin
            w_cnt_next   = LINE_W'(1);
            w_state_next = ST_VERIFY;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      ST_VERIFY: begin
        if (w_vs_rise) begin
          w_lines_next = r_cnt;
          w_cnt_next   = '0;
          if (r_cnt >= LINE_W'(MIN_LINES)) begin
            w_h_size_next = LINE_W'(r_w - RUN_W'(WIN));
            w_locked_next = 1'b1;
            w_state_next  = ST_RUN;
          end else begin
            w_state_next = ST_MEASURE;
          end
        end else if (w_run_done) begin
          if (w_match) begin
            w_cnt_next = w_cnt_inc;
          end else begin
            w_cnt_next   = '0;
            w_state_next = ST_MEASURE;
          end
        end
      end
      ST_RUN: begin
        if (w_vs_rise) begin
          w_lines_next = r_cnt;
          w_cnt_next   = '0;
        end else if (w_run_done) begin
          if (w_match) begin
            w_cnt_next = w_cnt_inc;
          end else begin
            // h_size is left alone so the delay line keeps its last good length.
            w_err_next    = 1'b1;
            w_locked_next = 1'b0;
            w_cnt_next    = '0;
            w_state_next  = ST_MEASURE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_filt_en_next = w_locked_next & ~i_force_bypass;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_w       <= '0;
      r_cnt     <= '0;
      r_h_size  <= LINE_W'(DEFAULT_H - WIN);
      r_lines   <= '0;
      r_width   <= '0;
      r_locked  <= 1'b0;
      r_filt_en <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_w      <= w_w_next;
      r_cnt    <= w_cnt_next;
      r_h_size <= w_h_size_next;
      r_lines  <= w_lines_next;
      r_width  <= w_width_next;
      r_locked <= w_locked_next;
      r_err    <= w_err_next;
      if (i_ce)
        r_filt_en <= w_filt_en_next;
    end
  end

  assign o_h_size  = r_h_size;
  assign o_filt_en = r_filt_en;
  assign o_locked  = r_locked;
  assign o_err     = r_err;
  assign o_width   = r_width;
  assign o_lines   = r_lines;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed bench: expected run widths/err queued per driven line, checked one cycle after de falls.
module tb_median_frame_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_ce = 1'b1;
  logic        i_de = 1'b0;
  logic        i_hsync = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_force_bypass = 1'b0;
  logic [9:0]  o_h_size;
  logic        o_filt_en;
  logic        o_locked;
  logic        o_err;
  logic [10:0] o_width;
  logic [9:0]  o_lines;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int width;
    int err;
  } exp_t;
  exp_t sb[$];

  median_frame_ctrl dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_ce           (i_ce),
    .i_de           (i_de),
    .i_hsync        (i_hsync),
    .i_vsync        (i_vsync),
    .i_force_bypass (i_force_bypass),
    .o_h_size       (o_h_size),
    .o_filt_en      (o_filt_en),
    .o_locked       (o_locked),
    .o_err          (o_err),
    .o_width        (o_width),
    .o_lines        (o_lines)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one de run of n ce-qualified cycles, optionally with a ce gap mid-line.
  task automatic drive_line(input int n, input int exp_w, input int exp_err, input int gap);
    exp_t e;
    exp_t got;
    e.width = exp_w;
    e.err   = exp_err;
    sb.push_back(e);
    i_de = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (gap > 0 && i == n / 2) begin
        i_ce = 1'b0;
        repeat (gap) tick();
        i_ce = 1'b1;
      end
    end
    i_de = 1'b0;
    tick();
    got = sb.pop_front();
    check("width", o_width, got.width);
    check("err", o_err, got.err);
    $display("line n=%0d width=%0d err=%0d locked=%0d filt_en=%0d", n, o_width, o_err, o_locked, o_filt_en);
    i_hsync = 1'b1;
    tick();
    i_hsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    $display("vsync locked=%0d filt_en=%0d h_size=%0d lines=%0d", o_locked, o_filt_en, o_h_size, o_lines);
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_h_size", o_h_size, 78);
    check("rst_filt_en", o_filt_en, 0);
    check("rst_locked", o_locked, 0);
    check("rst_err", o_err, 0);
    check("rst_width", o_width, 0);
    check("rst_lines", o_lines, 0);
    i_rst_n = 1'b1;
    repeat (2) tick();

    // Short frame: 3 lines is below the line minimum, no lock.
    vsync_pulse();
    for (int l = 0; l < 3; l++) drive_line(83, 83, 0, 0);
    vsync_pulse();
    check("short_lines", o_lines, 3);
    check("short_locked", o_locked, 0);
    check("short_filt_en", o_filt_en, 0);

    // Full 83x10 frame verifies and locks at the following vsync.
    for (int l = 0; l < 10; l++) drive_line(83, 83, 0, 0);
    check("verify_not_locked_yet", o_locked, 0);
    vsync_pulse();
    check("lock_locked", o_locked, 1);
    check("lock_filt_en", o_filt_en, 1);
    check("lock_h_size", o_h_size, 78);
    check("lock_lines", o_lines, 10);

    // Locked frame, one line broken by a ce gap still measures 83.
    for (int l = 0; l < 10; l++) drive_line(83, 83, 0, (l == 4) ? 7 : 0);
    vsync_pulse();
    check("run_lines", o_lines, 10);
    check("run_locked", o_locked, 1);

    // force_bypass drops filt_en only.
    i_force_bypass = 1'b1;
    tick();
    check("bypass_filt_en", o_filt_en, 0);
    check("bypass_locked", o_locked, 1);
    check("bypass_h_size", o_h_size, 78);
    i_force_bypass = 1'b0;
    tick();
    check("release_filt_en", o_filt_en, 1);

    // Width change while locked.
    drive_line(83, 83, 0, 0);
    sb.push_back('{width: 82, err: 1});
    i_de = 1'b1;
    repeat (82) tick();
    i_de = 1'b0;
    tick();
    begin
      exp_t got;
      got = sb.pop_front();
      check("mismatch_width", o_width, got.width);
      check("mismatch_err", o_err, got.err);
    end
    check("mismatch_locked", o_locked, 0);
    check("mismatch_filt_en", o_filt_en, 0);
    check("mismatch_h_size", o_h_size, 78);
    $display("mismatch width=%0d err=%0d locked=%0d", o_width, o_err, o_locked);
    tick();
    check("mismatch_err_pulse_end", o_err, 0);
    repeat (3) tick();

    // Too-narrow line errors in MEASURE, then 64-wide frame relocks.
    vsync_pulse();
    drive_line(4, 4, 1, 0);
    for (int l = 0; l < 10; l++) drive_line(64, 64, 0, 0);
    vsync_pulse();
    check("relock64_locked", o_locked, 1);
    check("relock64_h_size", o_h_size, 59);
    check("relock64_lines", o_lines, 10);
    check("relock64_filt_en", o_filt_en, 1);

    // Asynchronous reset mid-line.
    i_de = 1'b1;
    repeat (5) tick();
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_h_size", o_h_size, 78);
    check("arst_filt_en", o_filt_en, 0);
    check("arst_locked", o_locked, 0);
    check("arst_err", o_err, 0);
    check("arst_width", o_width, 0);
    check("arst_lines", o_lines, 0);
    $display("async reset h_size=%0d locked=%0d width=%0d", o_h_size, o_locked, o_width);
    i_de = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (2) tick();

    // vsync rising during de: the partial run must be discarded.
    i_de = 1'b1;
    repeat (4) tick();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    repeat (3) tick();
    i_de = 1'b0;
    repeat (2) tick();
    check("partial_width", o_width, 0);
    check("partial_err", o_err, 0);
    $display("partial run width=%0d", o_width);
    repeat (2) tick();

    // Saturating run is out of range, then 20-wide frame relocks.
    drive_line(2050, 2047, 1, 0);
    for (int l = 0; l < 6; l++) drive_line(20, 20, 0, 0);
    vsync_pulse();
    check("relock20_locked", o_locked, 1);
    check("relock20_h_size", o_h_size, 15);
    check("relock20_lines", o_lines, 6);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
